// File: rtl/msa_issue_seq.sv
// rtl/msa_issue_seq.sv - MSA issue sequencer: single-op issue and MI10 four-beat vector load/store
module msa_issue_seq #(
    parameter logic [3:0] FMT_MI10 = 4'b1000,
    parameter int         ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [3:0]        format,
    input  logic [31:0]       base,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              issue_valid,
    output logic [31:0]       issue_instr,
    output logic [3:0]        issue_format,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_beat,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [127:0]      ld_data,
    output logic              ld_valid,
    output logic              align_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        MEM   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    instr_q;
    logic [3:0]     format_q;
    logic [31:0]    base_q;
    logic [1:0]     beat_q;
    logic [127:0]   ld_data_q;
    logic           done_held_q;

    logic           accept;
    logic           in_is_mi10;
    logic [31:0]    s10_ext;
    logic [31:0]    vec_addr;
    logic [31:0]    beat_addr;
    logic           misaligned;

    // MI10 shares its format code with 2RF; the minor opcode field tells them apart.
    assign in_is_mi10 = (format == FMT_MI10) && (instr[5:3] == 3'b100);
    assign accept     = in_valid && in_ready;

    // Vector base address from the latched op; constant for the whole MEM visit.
    assign s10_ext    = {{22{instr_q[25]}}, instr_q[25:16]};
    assign vec_addr   = base_q + (s10_ext << instr_q[1:0]);
    assign beat_addr  = vec_addr + {28'd0, beat_q, 2'b00};
    assign misaligned = (vec_addr[1:0] != 2'b00);

    // Next-state and handshake/strobe outputs.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        issue_valid = 1'b0;
        mem_req     = 1'b0;
        align_err   = 1'b0;
        ld_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_d = in_is_mi10 ? MEM : ISSUE;
                end
            end
            ISSUE: begin
                issue_valid = 1'b1;
                in_ready    = !ex_stall;
                if (!ex_stall) begin
                    if (accept) begin
                        state_d = in_is_mi10 ? MEM : ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            MEM: begin
                if (misaligned) begin
                    align_err = 1'b1;
                    state_d   = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack && (beat_q == 2'd3)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                issue_valid = 1'b1;
                // A stalled DONE keeps the issue slot up but reports the load only once.
                ld_valid    = !instr_q[2] && !done_held_q;
                if (!ex_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we       = mem_req && instr_q[2];
    assign mem_addr     = mem_req ? ADDR_W'(beat_addr) : '0;
    assign mem_beat     = mem_req ? beat_q : 2'd0;
    assign issue_instr  = instr_q;
    assign issue_format = format_q;
    assign ld_data      = ld_data_q;
    assign busy         = (state_q != IDLE);

    // State, latched op, beat counter and load assembly register.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            format_q    <= '0;
            base_q      <= '0;
            beat_q      <= '0;
            ld_data_q   <= '0;
            done_held_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_held_q <= (state_q == DONE) && ex_stall;
            if (accept) begin
                instr_q  <= instr;
                format_q <= format;
                base_q   <= base;
                beat_q   <= 2'd0;
            end else if (mem_req && mem_ack) begin
                if (!instr_q[2]) begin
                    ld_data_q[{beat_q, 5'b00000} +: 32] <= mem_rdata;
                end
                beat_q <= beat_q + 2'd1;
            end
        end
    end

endmodule
